// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences a shared-memory datapath one step per clock,
// counts retired instructions and flags illegal encodings.
// Optional feature macro: MC_MEM_WAIT_EN (FETCH/MEMRD/MEMWR stall until mem_ready).
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [5:0]       op_code,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dest,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic             halted,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11,
    StRst      = 4'd12,
    StHalt     = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             mem_ok;
  logic             rtype_legal;
  logic [2:0]       rtype_alu;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  // Without wait states every memory access completes in one cycle.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  // Decode funct into ALU operation and legality for R-type instructions.
  always_comb begin
    rtype_legal = 1'b1;
    rtype_alu   = AluAdd;
    case (funct)
      6'b100000: rtype_alu = AluAdd;
      6'b100010: rtype_alu = AluSub;
      6'b100100: rtype_alu = AluAnd;
      6'b100101: rtype_alu = AluOr;
      6'b101010: rtype_alu = AluSlt;
      default: begin
        rtype_legal = 1'b0;
        rtype_alu   = AluAdd;
      end
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StRst;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    pc_en       = 1'b0;
    ir_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dest    = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    pc_src      = 2'b00;
    illegal     = 1'b0;
    halted      = 1'b0;
    case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        ir_write    = mem_ok;
        pc_en       = mem_ok;
        alu_src_b   = 2'b01;
        alu_control = AluAdd;
        if (mem_ok) state_d = StDecode;
      end
      StDecode: begin
        // Branch target is precomputed here while the opcode is decoded.
        alu_src_b   = 2'b11;
        alu_control = AluAdd;
        if ((op_code == OpLw) || (op_code == OpSw)) begin
          state_d = StMemAdr;
        end else if ((op_code == OpRtype) && rtype_legal) begin
          state_d = StExecute;
        end else if (op_code == OpBeq) begin
          state_d = StBranch;
        end else if (op_code == OpAddi) begin
          state_d = StAddiExec;
        end else if (op_code == OpJ) begin
          state_d = StJump;
        end else begin
          illegal = 1'b1;
          state_d = ILLEGAL_HALT ? StHalt : StFetch;
        end
      end
      StMemAdr: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = AluAdd;
        state_d     = (op_code == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        i_or_d = 1'b1;
        if (mem_ok) state_d = StMemWb;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        i_or_d    = 1'b1;
        mem_write = mem_ok;
        if (mem_ok) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExecute: begin
        alu_src_a   = 1'b1;
        alu_control = rtype_alu;
        state_d     = StAluWb;
      end
      StAluWb: begin
        reg_dest  = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a   = 1'b1;
        alu_control = AluSub;
        pc_src      = 2'b01;
        pc_en       = zero;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StAddiExec: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = AluAdd;
        state_d     = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt: halted = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  assign state_o     = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed and random instruction streams
// compared against per-instruction step tables derived from the instruction semantics.
module tb_mips_multicycle_ctrl;

`ifdef MC_MEM_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n, arst_h_n;
  logic [5:0] op_code, funct, op_h, funct_h;
  logic       zero, mem_ready;

  // Main DUT: narrow counter so wrap is reachable; illegal skips.
  logic       pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dest, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       illegal, halted;
  logic [3:0] state_o, instr_count;

  // Second DUT: illegal instruction halts.
  logic        h_pc_en, h_ir_write, h_i_or_d, h_mem_write, h_reg_write, h_reg_dest;
  logic        h_mem_to_reg, h_alu_src_a;
  logic [1:0]  h_alu_src_b, h_pc_src;
  logic [2:0]  h_alu_control;
  logic        h_illegal, h_halted;
  logic [3:0]  h_state_o;
  logic [15:0] h_instr_count;

  mips_multicycle_ctrl #(.CNT_W(4), .ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .arst_n(arst_n), .op_code(op_code), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .illegal(illegal), .halted(halted),
    .state_o(state_o), .instr_count(instr_count)
  );

  mips_multicycle_ctrl #(.CNT_W(16), .ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .arst_n(arst_h_n), .op_code(op_h), .funct(funct_h), .zero(zero),
    .mem_ready(mem_ready), .pc_en(h_pc_en), .ir_write(h_ir_write), .i_or_d(h_i_or_d),
    .mem_write(h_mem_write), .reg_write(h_reg_write), .reg_dest(h_reg_dest),
    .mem_to_reg(h_mem_to_reg), .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b),
    .alu_control(h_alu_control), .pc_src(h_pc_src), .illegal(h_illegal),
    .halted(h_halted), .state_o(h_state_o), .instr_count(h_instr_count)
  );

  logic [16:0] obs, obs_h;
  assign obs = {pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dest, mem_to_reg,
                alu_src_a, alu_src_b, alu_control, pc_src, illegal, halted};
  assign obs_h = {h_pc_en, h_ir_write, h_i_or_d, h_mem_write, h_reg_write, h_reg_dest,
                  h_mem_to_reg, h_alu_src_a, h_alu_src_b, h_alu_control, h_pc_src,
                  h_illegal, h_halted};

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23, 6'h2b, 6'h04, 6'h08, 6'h02: return 1'b1;
      6'h00: return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) ||
                    (fn == 6'h2a);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] rtype_op(input logic [5:0] fn);
    case (fn)
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2a: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected control word for a step: what the datapath needs in that step.
  function automatic logic [16:0] exp_out(input int st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z,
                                          input logic rdy);
    logic pe, irw, iod, mw, rw, rd, m2r, sa, ill, hlt, ok;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {pe, irw, iod, mw, rw, rd, m2r, sa, ill, hlt} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    ok = WaitEn ? rdy : 1'b1;
    case (st)
      0:  begin irw = ok; pe = ok; sb = 2'b01; alu = 3'b010; end
      1:  begin sb = 2'b11; alu = 3'b010; ill = !is_legal(op, fn); end
      2:  begin sa = 1'b1; sb = 2'b10; alu = 3'b010; end
      3:  iod = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin iod = 1'b1; mw = ok; end
      6:  begin sa = 1'b1; alu = rtype_op(fn); end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; alu = 3'b110; ps = 2'b01; pe = z; end
      9:  begin sa = 1'b1; sb = 2'b10; alu = 3'b010; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pe = 1'b1; end
      13: hlt = 1'b1;
      default: ;
    endcase
    return {pe, irw, iod, mw, rw, rd, m2r, sa, sb, alu, ps, ill, hlt};
  endfunction

  // Run one instruction on the main DUT, checking every cycle against its step list.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int steps[$];
    bit retires;
    retires = 1'b1;
    if (!is_legal(op, fn)) begin steps = '{0, 1}; retires = 1'b0; end
    else if (op == 6'h23) steps = '{0, 1, 2, 3, 4};
    else if (op == 6'h2b) steps = '{0, 1, 2, 5};
    else if (op == 6'h00) steps = '{0, 1, 6, 7};
    else if (op == 6'h04) steps = '{0, 1, 8};
    else if (op == 6'h08) steps = '{0, 1, 9, 10};
    else steps = '{0, 1, 11};
    foreach (steps[i]) begin
      int st;
      int tries;
      bit stall;
      st = steps[i];
      tries = 0;
      do begin
        bit waitable;
        @(negedge clk);
        waitable = (st == 0) || (st == 3) || (st == 5);
        op_code = (st == 0) ? 6'($urandom) : op;
        funct   = (st == 0) ? 6'($urandom) : fn;
        zero    = (st == 8) ? z : 1'($urandom);
        if (WaitEn && waitable && tries >= 3) mem_ready = 1'b1;
        else mem_ready = 1'($urandom);
        #1;
        chk($sformatf("state op=%h step%0d", op, i), 32'(state_o), 32'(st));
        chk($sformatf("ctrl op=%h st=%0d", op, st), 32'(obs),
            32'(exp_out(st, op, fn, zero, mem_ready)));
        if (i == 0 && tries == 0)
          chk("instr_count", 32'(instr_count), 32'(model_count % 16));
        stall = WaitEn && waitable && !mem_ready;
        tries++;
      end while (stall);
    end
    if (retires) model_count++;
  endtask

  initial begin
    arst_n = 1'b0; arst_h_n = 1'b0;
    op_code = '0; funct = '0; op_h = 6'h3f; funct_h = '0;
    zero = 1'b0; mem_ready = 1'b1;

    // Reset held: both DUTs park in RST with everything quiet.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst state", 32'(state_o), 32'd12);
    chk("rst outs", 32'(obs), 32'd0);
    chk("rst count", 32'(instr_count), 32'd0);
    chk("rst_h state", 32'(h_state_o), 32'd12);

    // Release main reset; first cycle still RST.
    arst_n = 1'b1; #1;
    chk("post-rst state", 32'(state_o), 32'd12);
    chk("post-rst outs", 32'(obs), 32'd0);

    // Directed: lw, beq taken/not taken, slt, illegal funct, illegal op, sw, addi, j.
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h00, 6'h2a, 1'b0);
    run_instr(6'h00, 6'h07, 1'b0);
    run_instr(6'h3f, 6'h20, 1'b0);
    run_instr(6'h2b, 6'h00, 1'b0);
    run_instr(6'h08, 6'h11, 1'b0);
    run_instr(6'h02, 6'h00, 1'b1);

    // Random stream, long enough for the 4-bit counter to wrap.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] rop, rfn;
      rfn = 6'($urandom);
      case ($urandom_range(0, 9))
        0: rop = 6'h23;
        1: rop = 6'h2b;
        2, 8: begin
          rop = 6'h00;
          case ($urandom_range(0, 4))
            0: rfn = 6'h20;
            1: rfn = 6'h22;
            2: rfn = 6'h24;
            3: rfn = 6'h25;
            default: rfn = 6'h2a;
          endcase
        end
        3, 9: rop = 6'h04;
        4: rop = 6'h08;
        5: rop = 6'h02;
        6: rop = ($urandom_range(0, 1) == 0) ? 6'h3f : 6'h0d;
        default: begin rop = 6'h00; rfn = ($urandom_range(0, 1) == 0) ? 6'h07 : 6'h21; end
      endcase
      run_instr(rop, rfn, 1'($urandom));
    end

    // Count after the stream, then reset asynchronously in the middle of a lw.
    @(negedge clk);
    mem_ready = 1'b1; op_code = 6'h23; funct = 6'h00; #1;
    chk("final count", 32'(instr_count), 32'(model_count % 16));
    chk("final state", 32'(state_o), 32'd0);
    @(negedge clk); #1;
    chk("mid lw decode", 32'(state_o), 32'd1);
    @(negedge clk); #1;
    chk("mid lw memadr", 32'(state_o), 32'd2);
    arst_n = 1'b0; #1;
    chk("async rst state", 32'(state_o), 32'd12);
    chk("async rst outs", 32'(obs), 32'd0);
    chk("async rst count", 32'(instr_count), 32'd0);

    // Halting variant: illegal opcode parks in HALT until reset.
    @(negedge clk);
    arst_h_n = 1'b1; op_h = 6'h3f; #1;
    chk("h rst cycle", 32'(h_state_o), 32'd12);
    @(negedge clk); #1;
    chk("h fetch", 32'(h_state_o), 32'd0);
    chk("h fetch outs", 32'(obs_h), 32'(exp_out(0, op_h, funct_h, zero, 1'b1)));
    @(negedge clk); #1;
    chk("h decode", 32'(h_state_o), 32'd1);
    chk("h illegal pulse", 32'(obs_h), 32'(exp_out(1, op_h, funct_h, zero, 1'b1)));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      op_h = 6'($urandom); #1;
      chk("h halt state", 32'(h_state_o), 32'd13);
      chk("h halt outs", 32'(obs_h), 32'(exp_out(13, op_h, funct_h, zero, 1'b1)));
    end
    chk("h count", 32'(h_instr_count), 32'd0);
    arst_h_n = 1'b0; #1;
    chk("h reset exit", 32'(h_state_o), 32'd12);
    chk("h reset outs", 32'(obs_h), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM that sequences a shared-memory multicycle MIPS datapath (one ALU, one memory port, instruction register).
- Decodes op_code/funct from the datapath's instruction register.
- Drives every datapath mux select and write enable, one step per clock.
- Counts retired instructions and flags illegal encodings.

Parameters:
CNT_W, 16, width of retired-instruction counter
ILLEGAL_HALT, 0, 1 = illegal instruction parks the FSM in HALT until reset; 0 = skip and refetch

Ports:
clk  in  1  system clock
arst_n  in  1  reset, asynchronous, active-low
op_code  in  6  IR[31:26], stable from the cycle after FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory handshake (used only with MC_MEM_WAIT_EN)
pc_en  out  1  PC register load enable
ir_write  out  1  instruction register load
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_write  out  1  memory write strobe
reg_write  out  1  register file write
reg_dest  out  1  write address select: 0=rt, 1=rd
mem_to_reg  out  1  write data select: 0=ALUOut, 1=memory data
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
illegal  out  1  one-cycle pulse on illegal decode
halted  out  1  FSM in HALT
state_o  out  4  current state encoding (debug)
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset: state=RST(12). All outputs are 0, including instr_count.
- RST always advances to FETCH on the next clock.
- Outputs decode combinationally from the state register only. Exceptions:
  - pc_en in BRANCH follows zero.
  - alu_control in EXECUTE follows funct.
- Any output not listed for a state is 0.
- State encodings, asserted outputs and next state:
  - FETCH(0): ir_write=1, pc_en=1, alu_src_b=01, add. -> DECODE.
  - DECODE(1): alu_src_b=11, add (branch target precompute). Next state by op_code:
    - 100011/101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEXEC
    - 000010 -> JUMP
    - else -> illegal handling
  - MEMADR(2): alu_src_a=1, alu_src_b=10, add. -> MEMRD for lw, MEMWR for sw.
  - MEMRD(3): i_or_d=1. -> MEMWB.
  - MEMWB(4): mem_to_reg=1, reg_write=1. -> FETCH.
  - MEMWR(5): i_or_d=1, mem_write=1. -> FETCH.
  - EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_control from funct:
    - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
    - -> ALUWB
  - ALUWB(7): reg_dest=1, reg_write=1. -> FETCH.
  - BRANCH(8): alu_src_a=1, sub, pc_src=01, pc_en=zero. -> FETCH.
  - ADDIEXEC(9): alu_src_a=1, alu_src_b=10, add. -> ADDIWB.
  - ADDIWB(10): reg_write=1, reg_dest=0, mem_to_reg=0. -> FETCH.
  - JUMP(11): pc_src=10, pc_en=1. -> FETCH.
  - HALT(13): all enables 0, halted=1. Exits only via reset.
- Illegal decode:
  - Triggers: unsupported op_code, or op_code=000000 with a funct outside the five listed.
  - Detected in DECODE: illegal=1 for that cycle.
  - Next state is HALT if ILLEGAL_HALT=1, else FETCH.
  - Not counted as retired.
- Unused encodings 14, 15 -> FETCH next clock, no outputs asserted.
- Latency (no wait states): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
- instr_count wraps from 2^CNT_W-1 to 0 with no flag.
- Asynchronous reset mid-instruction: immediate return to RST; all outputs 0 in the same cycle.

Optional Feature:
MC_MEM_WAIT_EN
- Defined:
  - FETCH, MEMRD and MEMWR hold their state and mux selects while mem_ready=0.
  - ir_write, pc_en (in FETCH) and mem_write assert only in the cycle mem_ready=1; the state then advances.
  - Each wait cycle adds exactly one cycle of latency.
- Undefined: mem_ready is ignored and every state lasts one cycle.

Test Plan:
- Reset held, then released -> first cycle state_o=12 with all outputs 0; next cycle state_o=0, ir_write=1, pc_en=1.
- lw (op 100011) -> states 0,1,2,3,4 over 5 cycles; reg_write=1 only in state 4, with mem_to_reg=1; instr_count 0->1.
- beq (op 000100):
  - zero=1 -> pc_en=1, pc_src=01, alu_control=110 in state 8.
  - zero=0 -> pc_en=0.
  - 3 cycles each.
- R-type slt (funct 101010) -> alu_control=111 in state 6; reg_dest=1, reg_write=1 in state 7. Funct 000111 -> illegal pulse, no reg_write, instr_count unchanged.
- Op 111111:
  - ILLEGAL_HALT=0 -> illegal pulse, back to state 0.
  - ILLEGAL_HALT=1 -> state 13, halted=1, holds for 20 cycles until arst_n pulse.
- MC_MEM_WAIT_EN, sw with mem_ready low 3 cycles in MEMWR -> mem_write low 3 cycles, then high 1 cycle; total 7 cycles. CNT_W=4 with 16 retirements -> instr_count wraps to 0.
